pipelined_rca: RTL and testbench
================================

# pipelined_rca

Parametrised, pipelined successor to the team's fixed-width ripple-carry adder. It splits a WIDTH-bit add or subtract into CHUNK-bit ripple segments, with one register stage per segment. Operands enter and results leave through valid/ready handshakes with full backpressure. Sustained throughput is one operation per clock. It sits in the datapath wherever 32-bit and wider adds must close timing at clock rates a full-width ripple chain cannot meet.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8: bits per pipeline segment; STAGES = WIDTH/CHUNK (derived, not overridable).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a, b  in  WIDTH each  operands (unsigned or two's complement).
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (computed as a+~b+1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Accept when in_valid & in_ready at a rising edge. Register b as ~b when sub=1. Register the effective carry-in as 1 when sub=1, else cin.
- Stage k (0..STAGES-1) holds a valid bit, sum bits [k*CHUNK+CHUNK-1:0] resolved so far, the carry into the next chunk, and the unconsumed high bits of a and b.
- Stage 0 computes chunk 0 on accept. Stage k>0 computes chunk k from stage k-1's carry when stage k-1 advances.
- Last stage computes the MSB carry-in as well as cout, used for ovf.
- Advance enables: en_last = ~v_last | out_ready; en_k = ~v_k | en_{k+1}; in_ready = en_0. Bubbles collapse. There is no combinational path from in_valid to out_valid.
- Stage k valid loads the previous valid (stage 0: in_valid) when en_k, else holds. Data registers load only when the incoming valid is 1.
- sum/cout/ovf are driven directly from last-stage registers. They stay stable while out_valid & ~out_ready.
- Wrap-around: results are modulo 2^WIDTH. Example: 0xFFFFFFFF+1 gives sum=0, cout=1.
- CHUNK==WIDTH: single stage, latency 1.

## Timing
- Reset (async assert, synchronous-safe deassert by the system): all valid bits 0, all data registers 0. Outputs: out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once out of reset.
- Reset mid-operation drops every in-flight beat. No partial result is ever presented.
- Latency: a beat accepted at edge N appears on outputs right after edge N+STAGES-1 if no stall occurs.
- Throughput: one beat/cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0. No beat is lost or duplicated.
- Simultaneous accept at input and drain at output when full: allowed in the same cycle, and the pipeline stays full.
- Ordering: strictly in order.

## Structure
- Shared package `rca_pkg`: the ADD/SUB opcode constant and the function computing STAGES from WIDTH/CHUNK.
- Sub-module `rca_chunk`: combinational CHUNK-bit ripple adder built from the team's Full_Adder cell. Outputs sum, cout and carry into its MSB. pipelined_rca instantiates STAGES copies via generate.

## Test plan
- WIDTH=32, CHUNK=8, out_ready=1: a=0x12345678, b=0x11111111, cin=1, sub=0 -> after 4 cycles sum=0x2345678A, cout=0, ovf=0.
- Carry across all chunk boundaries: a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0. Then a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure: stream 10 random beats, hold out_ready=0 for 6 cycles mid-stream -> in_ready falls once 4 beats are buffered. All 10 results arrive in order and match the reference model; outputs stay stable while stalled.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0, sum=0 immediately. After release, the first new beat's result is correct and no stale beat appears.
- Parameter sweep: CHUNK=WIDTH=16 (latency 1) and WIDTH=64/CHUNK=4 (latency 16). 1000 random beats each, checked against a+b+cin modulo 2^WIDTH.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: opcode encoding
// and the stage-count derivation.
package rca_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the ripple element of rca_chunk.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the final segment can form signed overflow.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    Full_Adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca.sv
// WIDTH-bit add/subtract split into CHUNK-bit ripple segments, one register
// stage per segment, with valid/ready handshakes and full backpressure.
module pipelined_rca
  import rca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_rca: WIDTH must be a positive multiple of CHUNK");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = (sub == OP_SUB) ? ~b : b;
  assign cin_eff = (sub == OP_SUB) ? 1'b1 : cin;

  logic             vld      [STAGES];
  logic             vld_in   [STAGES];
  logic             en       [STAGES];
  logic             carry_r  [STAGES];
  logic [WIDTH-1:0] sum_r    [STAGES];
  logic [WIDTH-1:0] a_r      [STAGES];
  logic [WIDTH-1:0] b_r      [STAGES];
  logic [WIDTH-1:0] sum_prev [STAGES];
  logic [WIDTH-1:0] sum_next [STAGES];
  logic [WIDTH-1:0] a_src    [STAGES];
  logic [WIDTH-1:0] b_src    [STAGES];
  logic             c_src    [STAGES];
  logic [CHUNK-1:0] ch_sum   [STAGES];
  logic             ch_cout  [STAGES];
  logic             ch_cmsb  [STAGES];
  logic             ovf_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign vld_in[k]   = in_valid;
      assign a_src[k]    = a;
      assign b_src[k]    = b_eff;
      assign c_src[k]    = cin_eff;
      assign sum_prev[k] = '0;
    end else begin : g_next
      assign vld_in[k]   = vld[k-1];
      assign a_src[k]    = a_r[k-1];
      assign b_src[k]    = b_r[k-1];
      assign c_src[k]    = carry_r[k-1];
      assign sum_prev[k] = sum_r[k-1];
    end

    // A stage may load when it is empty or its successor is moving on.
    if (k == LAST) begin : g_en_last
      assign en[k] = ~vld[k] | out_ready;
    end else begin : g_en_mid
      assign en[k] = ~vld[k] | en[k+1];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_src[k][k*CHUNK +: CHUNK]),
      .b    (b_src[k][k*CHUNK +: CHUNK]),
      .cin  (c_src[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k]),
      .cmsb (ch_cmsb[k])
    );

    // Bits at and above chunk k are still zero in the previous stage's sum.
    assign sum_next[k] = sum_prev[k] | (WIDTH'(ch_sum[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k]     <= 1'b0;
        carry_r[k] <= 1'b0;
        sum_r[k]   <= '0;
        a_r[k]     <= '0;
        b_r[k]     <= '0;
      end
      ovf_r <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld[k] <= vld_in[k];
          if (vld_in[k]) begin
            sum_r[k]   <= sum_next[k];
            a_r[k]     <= a_src[k];
            b_r[k]     <= b_src[k];
            carry_r[k] <= ch_cout[k];
          end
        end
      end
      if (en[LAST] && vld_in[LAST]) begin
        ovf_r <= ch_cout[LAST] ^ ch_cmsb[LAST];
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = vld[LAST];
  assign sum       = sum_r[LAST];
  assign cout      = carry_r[LAST];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed and streaming checks of pipelined_rca at 32/8, 16/16 and 64/4.
module tb_pipelined_rca;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, sub, out_ready;
  logic [63:0] a, b;
  int          sel;

  always #5 clk = ~clk;

  logic        ir0, ov0, co0, of0, ir1, ov1, co1, of1, ir2, ov2, co2, of2;
  logic [31:0] s0;
  logic [15:0] s1;
  logic [63:0] s2;
  logic        iv0, iv1, iv2;
  logic        in_r, out_v, out_c, out_o;
  logic [63:0] out_s;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  always_comb begin
    in_r = ir0; out_v = ov0; out_c = co0; out_o = of0; out_s = {32'd0, s0};
    case (sel)
      1: begin in_r = ir1; out_v = ov1; out_c = co1; out_o = of1; out_s = {48'd0, s1}; end
      2: begin in_r = ir2; out_v = ov2; out_c = co2; out_o = of2; out_s = s2; end
      default: ;
    endcase
  end

  pipelined_rca #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0));

  pipelined_rca #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1));

  pipelined_rca #(.WIDTH(64), .CHUNK(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2));

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum} for a w-bit operation.
  function automatic logic [65:0] model(input int w, input logic [63:0] aa, input logic [63:0] bb,
                                        input logic ci, input logic sb);
    logic [63:0] mask, hmask, beff;
    logic [64:0] full, low;
    logic        c, co, cm;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    hmask = mask >> 1;
    beff  = sb ? (~bb & mask) : (bb & mask);
    c     = sb ? 1'b1 : ci;
    full  = {1'b0, aa & mask} + {1'b0, beff} + {64'd0, c};
    low   = {1'b0, aa & hmask} + {1'b0, beff & hmask} + {64'd0, c};
    co    = full[w];
    cm    = low[w-1];
    return {cm ^ co, co, full[63:0] & mask};
  endfunction

  task automatic send_one(input string nm, input int lat_exp, input logic [63:0] aa, input logic [63:0] bb,
                          input logic ci, input logic sb, input logic [63:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({nm, " in_ready"}, in_r, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_v && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, " latency"}, lat, lat_exp);
    chk({nm, " sum"}, out_s, es);
    chk({nm, " cout/ovf"}, {out_c, out_o}, {ec, eo});
  endtask

  task automatic stream(input string nm, input int w, input int n, input int st0, input int stl,
                        input bit rnd, input bit check_fall, input int stg);
    logic [65:0] q[$];
    logic [65:0] exp, held;
    bit prev_stall, fall_seen;
    int sent, recv, cyc;
    prev_stall = 0; fall_seen = 0; sent = 0; recv = 0; cyc = 0; held = '0;
    while (recv < n && cyc < n * 6 + 200) begin
      @(negedge clk);
      cyc++;
      if (cyc >= st0 && cyc < st0 + stl) out_ready = 1'b0;
      else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sent < n) begin
        in_valid = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk({nm, " hold"}, {out_v, out_o, out_c, out_s}, {1'b1, held});
      prev_stall = out_v && !out_ready;
      held = {out_o, out_c, out_s};
      if (out_v && out_ready) begin
        chk({nm, " result expected"}, q.size() != 0, 1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          chk({nm, " sum"}, out_s, exp[63:0]);
          chk({nm, " ovf/cout"}, {out_o, out_c}, exp[65:64]);
          recv++;
        end
      end
      if (check_fall && !fall_seen && in_valid && !in_r) begin
        fall_seen = 1;
        chk({nm, " buffered at stall"}, q.size(), stg);
      end
      if (in_valid && in_r) begin
        q.push_back(model(w, a, b, cin, sub));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({nm, " beats received"}, recv, n);
    if (check_fall) chk({nm, " in_ready fell"}, fall_seen, 1);
  endtask

  initial begin
    vecs[0] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};
    vecs[9] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sel = 0;
    #3;
    chk("reset outputs", {out_v, out_c, out_o, out_s}, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 chk($sformatf("in_ready after reset w%0d", s), in_r, 1);
    end
    sel = 0;

    for (int i = 0; i < 10; i++)
      send_one($sformatf("vec%0d", i), 3, {32'd0, vecs[i].a}, {32'd0, vecs[i].b}, vecs[i].cin,
               vecs[i].sub, {32'd0, vecs[i].sum}, vecs[i].cout, vecs[i].ovf);

    stream("bp", 32, 10, 5, 6, 1'b0, 1'b1, 4);

    // Three beats in flight, then reset while the oldest is on the outputs.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'(i + 1); b = 64'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("pre-reset head", {out_v, out_s}, {1'b1, 64'd2});
    rst = 1'b1;
    #1 chk("mid reset outputs", {out_v, out_c, out_o, out_s}, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send_one("after reset", 3, 64'h0000FFFF, 64'h1, 1'b0, 1'b0, 64'h00010000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("no stale beat %0d", i), out_v, 0);
    end

    sel = 1;
    send_one("w16 wrap", 0, 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    stream("w16", 16, 1000, -1, 0, 1'b1, 1'b0, 1);
    sel = 2;
    send_one("w64 wrap", 15, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    stream("w64", 64, 1000, -1, 0, 1'b1, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
